// File: rtl/panel_pkg.sv
// panel_pkg: shared frame geometry and scan FSM encodings for the front-panel scan chain
package panel_pkg;
   localparam int FRAME_BITS = 21;
   localparam int SW_BITS    = 16;
   localparam int PB_BITS    = 5;
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] LOAD  = 2'd1;
   localparam logic [1:0] SHIFT = 2'd2;
   localparam logic [1:0] GAP   = 2'd3;
endpackage

// File: rtl/pb_debounce.sv
// pb_debounce: frame-rate debouncer for one pushbutton
// Ports: clk, rst_n (async, active-low); commit strobes one frame; raw is this frame's
// sample; level is the debounced state; press pulses for one cycle on a debounced rise.
module pb_debounce #(
   parameter int DEB_FRAMES = 3
) (
   input  logic clk,
   input  logic rst_n,
   input  logic commit,
   input  logic raw,
   output logic level,
   output logic press
);
   localparam int CW = $clog2(DEB_FRAMES + 1);
   logic [CW-1:0] cnt;
   logic hit;
   assign hit = int'(cnt) + 1 == DEB_FRAMES;
   // The counter is always cleared when it would reach DEB_FRAMES, so it never wraps.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt   <= '0;
         level <= 1'b0;
         press <= 1'b0;
      end else begin
         press <= 1'b0;
         if (commit) begin
            if (raw == level) cnt <= '0;
            else if (hit) begin
               level <= raw;
               cnt   <= '0;
               press <= raw;
            end else cnt <= cnt + 1'b1;
         end
      end
   end
endmodule

// File: rtl/panel_scan_ctrl.sv
// panel_scan_ctrl: sequenced scan of a 21-bit PISO chain into switch state and debounced buttons
// Ports: clk, rst_n (async, active-low); en enables scanning; ser_in is the chain output;
// sr_load_n/sr_clk drive the chain; sw_out, pb_level, pb_press, frame_valid update at commit;
// busy is high outside IDLE.
module panel_scan_ctrl
   import panel_pkg::*;
#(
   parameter int CLK_DIV    = 4,
   parameter int SCAN_GAP   = 8,
   parameter int DEB_FRAMES = 3
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               en,
   input  logic               ser_in,
   output logic               sr_load_n,
   output logic               sr_clk,
   output logic [SW_BITS-1:0] sw_out,
   output logic [PB_BITS-1:0] pb_level,
   output logic [PB_BITS-1:0] pb_press,
   output logic               frame_valid,
   output logic               busy
);
   localparam int CMAX = CLK_DIV > SCAN_GAP ? CLK_DIV : SCAN_GAP;
   localparam int CW   = $clog2(CMAX + 1);
   localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
   localparam logic [CW-1:0] GAP_LAST = CW'(SCAN_GAP - 1);
   localparam logic [4:0]    BIT_LAST = 5'(FRAME_BITS - 1);
   logic [1:0]            state, state_n;
   logic [CW-1:0]         cnt, cnt_n;
   logic                  half, half_n;
   logic [4:0]            bidx, bidx_n;
   logic [FRAME_BITS-1:0] shreg, shreg_n;
   logic                  commit;
   // half=0 is the low half of a bit period, half=1 the high half; sampling happens as
   // the low half ends, just before the chain shifts on the rising sr_clk.
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      half_n  = half;
      bidx_n  = bidx;
      shreg_n = shreg;
      case (state)
         IDLE: begin
            cnt_n = '0;
            if (en) state_n = LOAD;
         end
         LOAD: begin
            if (cnt == DIV_LAST) begin
               state_n = SHIFT;
               cnt_n   = '0;
               half_n  = 1'b0;
               bidx_n  = '0;
            end else cnt_n = cnt + 1'b1;
         end
         SHIFT: begin
            if (cnt != DIV_LAST) cnt_n = cnt + 1'b1;
            else begin
               cnt_n  = '0;
               half_n = !half;
               if (!half) shreg_n = {shreg[FRAME_BITS-2:0], ser_in};
               else if (bidx == BIT_LAST) state_n = GAP;
               else bidx_n = bidx + 1'b1;
            end
         end
         default: begin
            if (cnt != GAP_LAST) cnt_n = cnt + 1'b1;
            else begin
               cnt_n   = '0;
               state_n = en ? LOAD : IDLE;
            end
         end
      endcase
   end
   assign commit = state == SHIFT && state_n == GAP;
   // Chain outputs are registered from the next state so they line up with the state
   // they belong to and never glitch.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         cnt         <= '0;
         half        <= 1'b0;
         bidx        <= '0;
         shreg       <= '0;
         sr_load_n   <= 1'b1;
         sr_clk      <= 1'b0;
         busy        <= 1'b0;
         frame_valid <= 1'b0;
         sw_out      <= '0;
      end else begin
         state       <= state_n;
         cnt         <= cnt_n;
         half        <= half_n;
         bidx        <= bidx_n;
         shreg       <= shreg_n;
         sr_load_n   <= state_n != LOAD;
         sr_clk      <= state_n == SHIFT && half_n;
         busy        <= state_n != IDLE;
         frame_valid <= commit;
         // Frame bit j sits at shreg[20-j]: bits 0..7 -> sw[7:0] msb first, 8..15 -> sw[15:8].
         if (commit) sw_out <= {shreg[12:5], shreg[20:13]};
      end
   end
   for (genvar i = 0; i < PB_BITS; i++) begin : g_pb
      pb_debounce #(.DEB_FRAMES(DEB_FRAMES)) u_deb (
         .clk    (clk),
         .rst_n  (rst_n),
         .commit (commit),
         .raw    (shreg[i]),
         .level  (pb_level[i]),
         .press  (pb_press[i])
      );
   end
endmodule

// File: tb/tb_panel_scan_ctrl.sv
// tb_panel_scan_ctrl: directed self-checking bench for panel_scan_ctrl with a PISO chain model
module tb_panel_scan_ctrl;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        en = 1'b0;
   logic        ser_in;
   logic        sr_load_n, sr_clk, frame_valid, busy;
   logic [15:0] sw_out;
   logic [4:0]  pb_level, pb_press;
   int          checks = 0;
   int          errors = 0;
   logic [20:0] pat = '0;
   int          idx = 0;

   panel_scan_ctrl dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .en          (en),
      .ser_in      (ser_in),
      .sr_load_n   (sr_load_n),
      .sr_clk      (sr_clk),
      .sw_out      (sw_out),
      .pb_level    (pb_level),
      .pb_press    (pb_press),
      .frame_valid (frame_valid),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   // Chain model: load presents frame bit 0, each sr_clk rise advances one bit.
   always @(negedge sr_load_n or posedge sr_clk) idx <= sr_load_n ? idx + 1 : 0;
   assign ser_in = idx < 21 ? pat[idx] : 1'b0;

   task automatic wait_fv(input int lim, output int n);
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (!frame_valid && n < lim);
      if (!frame_valid) begin
         checks++; errors++;
         $display("FAIL wait_fv: no frame_valid within %0d cycles", lim);
      end
   endtask

   task automatic test_reset;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({sr_load_n, sr_clk, frame_valid, busy} !== 4'b1000) begin
         errors++; $display("FAIL reset_ctl: got %b want 1000", {sr_load_n, sr_clk, frame_valid, busy});
      end
      checks++;
      if ({sw_out, pb_level, pb_press} !== 26'd0) begin
         errors++; $display("FAIL reset_data: got sw=%h lvl=%b prs=%b want 0", sw_out, pb_level, pb_press);
      end
      @(negedge clk) rst_n = 1'b1;
   endtask

   task automatic test_first_frame;
      int n = 0, low = 0, rises = 0, hi = 0, fall_at = 0;
      logic prev = 1'b0;
      pat = 21'h1;
      @(posedge clk); #1 en = 1'b1;
      do begin
         @(posedge clk); #1;
         n++;
         if (!sr_load_n) begin
            low++;
            if (fall_at == 0) fall_at = n;
         end
         if (sr_clk) begin
            hi++;
            if (!prev) rises++;
         end
         prev = sr_clk;
      end while (!frame_valid && n < 400);
      checks++; if (fall_at !== 1) begin errors++; $display("FAIL load_latency: got %0d want 1", fall_at); end
      checks++; if (n !== 173) begin errors++; $display("FAIL fv_latency: got %0d want 173", n); end
      checks++; if (low !== 4) begin errors++; $display("FAIL load_width: got %0d want 4", low); end
      checks++; if (rises !== 21) begin errors++; $display("FAIL sr_clk_pulses: got %0d want 21", rises); end
      checks++; if (hi !== 84) begin errors++; $display("FAIL sr_clk_high: got %0d want 84", hi); end
      checks++; if (sw_out !== 16'h0080) begin errors++; $display("FAIL sw_bit0: got %h want 0080", sw_out); end
      checks++; if (pb_level !== 5'b0) begin errors++; $display("FAIL pb_bit0: got %b want 00000", pb_level); end
   endtask

   task automatic test_sw_bit8;
      int n;
      pat = 21'h100;
      wait_fv(400, n);
      checks++; if (n !== 180) begin errors++; $display("FAIL frame_period: got %0d want 180", n); end
      checks++; if (sw_out !== 16'h8000) begin errors++; $display("FAIL sw_bit8: got %h want 8000", sw_out); end
   endtask

   task automatic test_pb0_debounce;
      int n;
      pat = 21'h100000;
      for (int f = 1; f <= 3; f++) begin
         wait_fv(400, n);
         checks++;
         if ({pb_level[0], pb_press[0]} !== {2{f == 3}}) begin
            errors++; $display("FAIL pb0_frame%0d: got lvl=%b prs=%b want %b", f, pb_level[0], pb_press[0], f == 3);
         end
      end
      checks++; if (sw_out !== 16'h0) begin errors++; $display("FAIL sw_zero: got %h want 0000", sw_out); end
      @(posedge clk); #1;
      checks++;
      if ({pb_level[0], pb_press} !== 6'b100000) begin
         errors++; $display("FAIL pb0_after: got lvl0=%b prs=%b want 1 00000", pb_level[0], pb_press);
      end
   endtask

   task automatic test_pb4_pattern;
      int n, presses = 0;
      int raw4 [6] = '{1, 1, 0, 1, 1, 1};
      for (int f = 0; f < 6; f++) begin
         pat = raw4[f] != 0 ? 21'h10000 : 21'h0;
         wait_fv(400, n);
         if (pb_press[4]) presses++;
         checks++;
         if (pb_level[4] !== (f == 5)) begin
            errors++; $display("FAIL pb4_frame%0d: got %b want %b", f + 1, pb_level[4], f == 5);
         end
      end
      checks++; if (presses !== 1) begin errors++; $display("FAIL pb4_presses: got %0d want 1", presses); end
   endtask

   task automatic test_en_drop;
      int n, gap_busy = 0, extra = 0;
      pat = 21'h8;
      repeat (100) @(posedge clk);
      #1 en = 1'b0;
      wait_fv(200, n);
      checks++; if (sw_out !== 16'h0010) begin errors++; $display("FAIL drop_sw: got %h want 0010", sw_out); end
      for (int k = 0; k < 7; k++) begin
         @(posedge clk); #1;
         if (busy) gap_busy++;
      end
      checks++; if (gap_busy !== 7) begin errors++; $display("FAIL drop_gap_busy: got %0d want 7", gap_busy); end
      @(posedge clk); #1;
      checks++;
      if ({busy, sr_load_n} !== 2'b01) begin
         errors++; $display("FAIL drop_idle: got busy=%b load_n=%b want 0 1", busy, sr_load_n);
      end
      repeat (250) begin
         @(posedge clk); #1;
         if (frame_valid || busy) extra++;
      end
      checks++; if (extra !== 0) begin errors++; $display("FAIL drop_stays_idle: got %0d active cycles want 0", extra); end
   endtask

   task automatic test_reset_mid;
      int n = 0, extra = 0;
      pat = 21'h3;
      @(posedge clk); #1 en = 1'b1;
      do begin
         @(posedge clk); #1;
         n++;
      end while (sr_load_n && n < 10);
      checks++; if (sr_load_n !== 1'b0) begin errors++; $display("FAIL mid_load: got %b want 0", sr_load_n); end
      repeat (86) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      checks++;
      if ({sr_load_n, sr_clk, frame_valid, busy} !== 4'b1000) begin
         errors++; $display("FAIL mid_reset_ctl: got %b want 1000", {sr_load_n, sr_clk, frame_valid, busy});
      end
      checks++;
      if ({sw_out, pb_level, pb_press} !== 26'd0) begin
         errors++; $display("FAIL mid_reset_data: got sw=%h lvl=%b prs=%b want 0", sw_out, pb_level, pb_press);
      end
      en = 1'b0;
      @(negedge clk) rst_n = 1'b1;
      repeat (300) begin
         @(posedge clk); #1;
         if (frame_valid || busy) extra++;
      end
      checks++; if (extra !== 0) begin errors++; $display("FAIL mid_no_commit: got %0d active cycles want 0", extra); end
   endtask

   initial begin
      test_reset;
      test_first_frame;
      test_sw_bit8;
      test_pb0_debounce;
      test_pb4_pattern;
      test_en_drop;
      test_reset_mid;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/panel_scan_ctrl.md
# panel_scan_ctrl

Scan controller for the front-panel serial input chain: 16 DIP switches plus 5 pushbuttons behind a parallel-in/serial-out shift-register chain. It drives the chain's load and shift clock, samples the serial stream, and assembles 21-bit frames. It publishes switch state every frame and debounced pushbutton levels with press pulses. It sits between the board pins and the user-logic registers and replaces free-running bit counting with a sequenced, restartable scan.

## Interface
Parameters:
- CLK_DIV, 4: system cycles per shift-clock half period; legal range ≥1.
- SCAN_GAP, 8: idle cycles between frames; ≥1.
- DEB_FRAMES, 3: consecutive agreeing frames required to change a pushbutton level; ≥1.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- en  in  1  scan enable.
- ser_in  in  1  serial data from the chain.
- sr_load_n  out  1  chain parallel load, active-low.
- sr_clk  out  1  chain shift clock.
- sw_out  out  16  switch state, updated each frame.
- pb_level  out  5  debounced pushbutton levels; 1 means pressed.
- pb_press  out  5  one-cycle pulse on debounced 0→1.
- frame_valid  out  1  one-cycle pulse when a frame commits.
- busy  out  1  high in any state other than IDLE.

## Operation
FSM states are IDLE, LOAD, SHIFT and GAP.
- IDLE: sr_load_n=1, sr_clk=0. If en=1, go to LOAD on the next cycle.
- LOAD: sr_load_n=0 for CLK_DIV cycles, then go to SHIFT.
- SHIFT: 21 bit periods of 2·CLK_DIV cycles each.
  - Each period has a low half (sr_clk=0), then a high half (sr_clk=1).
  - ser_in is captured on the last cycle of each low half.
  - A 5-bit bit index counts 0..20.
  - After the high half of bit 20, go to GAP.
- GAP: the first cycle commits the frame. The state lasts SCAN_GAP cycles, then goes to LOAD if en=1, else IDLE.
- en is sampled only in IDLE and at the end of GAP. Deasserting en mid-frame completes that frame.

Frame bit j, where j is in capture order:
- j=0..7 → sw_out[7−j].
- j=8..15 → sw_out[15−(j−8)].
- j=16..20 → raw pb[4−(j−16)].

Commit:
- sw_out is loaded directly from the frame (no debounce).
- frame_valid is pulsed.
- Per pushbutton bit i: if raw[i] equals pb_level[i], clear the counter.
  - Otherwise increment the counter.
  - When the counter reaches DEB_FRAMES, set pb_level[i]=raw[i] and clear the counter.
  - pb_press[i] pulses in the same cycle if the level rose.

## Timing
- Reset values: sr_load_n=1, sr_clk=0, sw_out=0, pb_level=0, pb_press=0, frame_valid=0, busy=0, state=IDLE, counters=0.
- Frame length = CLK_DIV + 42·CLK_DIV cycles from LOAD entry to GAP entry. With CLK_DIV=4 this is 172 cycles.
- en seen high in IDLE at cycle t:
  - sr_load_n falls at t+1.
  - frame_valid pulses at t+173 (CLK_DIV=4).
- Frame period in continuous scan = 43·CLK_DIV + SCAN_GAP. Defaults give 180 cycles.
- sw_out, pb_level, pb_press and frame_valid all change only in the commit cycle and are registered outputs.
- sr_clk and sr_load_n are registered, so there is no glitching.
- Reset asserted mid-frame: everything returns to reset values immediately and the partial frame is discarded. After release the block starts in IDLE.
- The debounce counter saturates only via its clear, so it never wraps. Counter width = clog2(DEB_FRAMES+1).

## Structure
- Shared package/include panel_pkg:
  - FRAME_BITS=21, SW_BITS=16, PB_BITS=5.
  - State encodings IDLE/LOAD/SHIFT/GAP.
- Sub-module pb_debounce: one per pushbutton, instantiated 5× via generate.
  - Inputs: clk, rst_n, commit, raw.
  - Outputs: level, press.
- The FSM, divider counter, bit index and 21-bit capture register live in panel_scan_ctrl.

## Test plan
- Reset, then en=1 with a chain model presenting only frame bit 0=1 → at the first frame_valid, sw_out=16'h0080 and pb_level=0.
- Only bit 8=1 → sw_out=16'h8000. Only bit 20=1 → after 3 frames pb_level=5'b00001, with pb_press[0] pulsing once, coincident with the third frame_valid.
- pb[4] raw pattern 1,1,0,1,1,1 across frames → pb_level[4] rises only at frame 6, and pb_press[4] pulses once.
- en held high, CLK_DIV=4, SCAN_GAP=8 → frame_valid every 180 cycles. sr_clk shows exactly 21 high pulses of 4 cycles per frame, and sr_load_n is low for 4 cycles.
- Drop en midway through SHIFT → the frame completes, frame_valid pulses, the FSM goes to IDLE, and busy=0 after the GAP.
- Assert rst_n low during SHIFT bit 10 → all outputs return to reset values asynchronously, and no frame_valid occurs for the aborted frame.
